// File: rtl/dat_mem_ctl_if.sv
// Load/store bus between the datapath and the data memory controller.
// The master drives requests; the slave returns read data and status.
interface dat_mem_ctl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
) ();
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat_in;
    logic [DW-1:0] dat_out;
    logic          rd_valid;
    logic          busy;

    modport master (
        output wr_en, rd_en, addr, dat_in,
        input  dat_out, rd_valid, busy
    );

    modport slave (
        input  wr_en, rd_en, addr, dat_in,
        output dat_out, rd_valid, busy
    );
endinterface

// File: rtl/dat_mem_ctl.sv
// Single-port data memory with registered read, read-valid strobe and an
// init sequencer that zero-fills the array and then writes two preload words.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  CLEAR | write 0 to word clr_cnt, advance; leave after the last word
//  LOAD0 | write PL_DAT0 to PL_ADDR0
//  LOAD1 | write PL_DAT1 to PL_ADDR1, drop busy
//  READY | serve load/store requests until the next reset
module dat_mem_ctl #(
    parameter int unsigned   DW       = 8,
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] PL_ADDR0 = AW'(60),
    parameter logic [DW-1:0] PL_DAT0  = DW'(8'h10),
    parameter logic [AW-1:0] PL_ADDR1 = AW'(61),
    parameter logic [DW-1:0] PL_DAT1  = DW'(8'hE0)
) (
    input  logic          clk,
    input  logic          reset,
    dat_mem_ctl_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD0 = 2'd1,
        LOAD1 = 2'd2,
        READY = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [DW-1:0] dat_out_q;
    logic          rd_valid_q;
    logic          busy_q;

    logic [DW-1:0] core [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    // One write port shared by the init sequencer and the store path.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
        if (!reset) begin
            unique case (state)
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_cnt;
                    mem_wdata = '0;
                end
                LOAD0: begin
                    mem_we    = 1'b1;
                    mem_waddr = PL_ADDR0;
                    mem_wdata = PL_DAT0;
                end
                LOAD1: begin
                    mem_we    = 1'b1;
                    mem_waddr = PL_ADDR1;
                    mem_wdata = PL_DAT1;
                end
                READY: begin
                    mem_we    = bus.wr_en;
                    mem_waddr = bus.addr;
                    mem_wdata = bus.dat_in;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            core[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            dat_out_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
            unique case (state)
                CLEAR: begin
                    // Compare on the last word so the AW-bit counter never wraps.
                    if (clr_cnt == {AW{1'b1}}) begin
                        state <= LOAD0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                LOAD0: begin
                    state <= LOAD1;
                end
                LOAD1: begin
                    state  <= READY;
                    busy_q <= 1'b0;
                end
                READY: begin
                    if (bus.rd_en) begin
                        rd_valid_q <= 1'b1;
                        // Same address for both requests: return the new data.
                        dat_out_q  <= bus.wr_en ? bus.dat_in : core[bus.addr];
                    end
                end
            endcase
        end
    end

    assign bus.dat_out  = dat_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
endmodule
